// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin share of one AXI write master port (AW/W/B) among NUM write engines
// Ports: axi_aclk clock, axi_rst async active-high reset;
//   s_awvalid/s_awaddr/s_awlen/s_awready  per-engine burst request and one-hot accept pulse
//   s_wdata/s_wvalid/s_wlast/s_wready     per-engine write data, wready gated to the data owner
//   s_bvalid/s_bresp                      response routed to the engine at the head of the grant FIFO
//   axi_aw*/axi_w*/axi_b*                 shared master side toward the memory controller
//   err_orphan_b                          sticky diagnostic: B response seen with nothing outstanding
module axi_wr_arbiter #(
  parameter int NUM            = 4,
  parameter int ASIZE          = 29,
  parameter int BURST_LEN_SIZE = 9,
  parameter int AXI_DSIZE      = 256,
  parameter int IDSIZE         = 4,
  parameter int OUTSTANDING    = 4
) (
  input  logic                          axi_aclk,
  input  logic                          axi_rst,
  input  logic [NUM-1:0]                s_awvalid,
  input  logic [NUM*ASIZE-1:0]          s_awaddr,
  input  logic [NUM*BURST_LEN_SIZE-1:0] s_awlen,
  output logic [NUM-1:0]                s_awready,
  input  logic [NUM*AXI_DSIZE-1:0]      s_wdata,
  input  logic [NUM-1:0]                s_wvalid,
  input  logic [NUM-1:0]                s_wlast,
  output logic [NUM-1:0]                s_wready,
  output logic [NUM-1:0]                s_bvalid,
  output logic [1:0]                    s_bresp,
  output logic [IDSIZE-1:0]             axi_awid,
  output logic [ASIZE-1:0]              axi_awaddr,
  output logic [BURST_LEN_SIZE-1:0]     axi_awlen,
  output logic                          axi_awvalid,
  input  logic                          axi_awready,
  output logic [AXI_DSIZE-1:0]          axi_wdata,
  output logic                          axi_wvalid,
  output logic                          axi_wlast,
  input  logic                          axi_wready,
  input  logic                          axi_bvalid,
  input  logic [1:0]                    axi_bresp,
  output logic                          axi_bready,
  output logic                          err_orphan_b
);
  localparam int IW = $clog2(NUM);
  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [IW:0] N = (IW+1)'(NUM);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, idx, pick;
  logic [IW:0] sum;
  logic found, grant, aw_hs, push, pop, empty, full;
  logic [IW-1:0] fifo [OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  // scanning from the farthest offset down lets the nearest requester at or after rr_ptr win
  always_comb begin
    pick = '0;
    found = 1'b0;
    sum = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      sum = sum >= N ? sum - N : sum;
      if (s_awvalid[sum[IW-1:0]]) begin
        pick = sum[IW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    grant = !axi_rst && state == IDLE && found && !full;
    aw_hs = state == ADDR && axi_awready;
    axi_wvalid = state == DATA && s_wvalid[idx];
    axi_wlast = state == DATA && s_wlast[idx];
    axi_wdata = state == DATA ? s_wdata[int'(idx)*AXI_DSIZE +: AXI_DSIZE] : '0;
    s_wready = state == DATA && axi_wready ? NUM'(1'b1) << idx : '0;
    s_awready = grant ? NUM'(1'b1) << pick : '0;
    case (state)
      IDLE:    if (grant) state_nx = ADDR;
      ADDR:    if (aw_hs) state_nx = DATA;
      DATA:    if (axi_wvalid && axi_wready && axi_wlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign empty = count == '0;
  assign full = count == (PW+1)'(OUTSTANDING);
  assign push = aw_hs;
  assign pop = axi_bvalid && !empty;
  assign axi_bready = !empty;
  assign s_bvalid = pop ? NUM'(1'b1) << fifo[rd_ptr] : '0;
  assign s_bresp = empty ? 2'b00 : axi_bresp;
  assign axi_awid = IDSIZE'(idx);
  always_ff @(posedge axi_aclk or posedge axi_rst)
    if (axi_rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      idx <= '0;
      axi_awaddr <= '0;
      axi_awlen <= '0;
      axi_awvalid <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_orphan_b <= 1'b0;
    end else begin
      state <= state_nx;
      axi_awvalid <= state_nx == ADDR;
      if (grant) begin
        idx <= pick;
        rr_ptr <= pick == IW'(NUM - 1) ? '0 : pick + 1'b1;
        axi_awaddr <= s_awaddr[int'(pick)*ASIZE +: ASIZE];
        axi_awlen <= s_awlen[int'(pick)*BURST_LEN_SIZE +: BURST_LEN_SIZE];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (axi_bvalid && empty) err_orphan_b <= 1'b1;
    end
  // grant-order storage needs no reset: entries are only read between push and pop
  always_ff @(posedge axi_aclk)
    if (push) fifo[wr_ptr] <= idx;
endmodule
